univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: DEPTH stages of WIDTH bits each.

---
 rtl/shift_pkg.sv | 10 +
 rtl/shift_stage.sv | 49 ++++
 rtl/univ_shift_reg.sv | 100 ++++++++++
 tb/tb_univ_shift_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Purpose : shared mode encoding for the universal shift register and its stages.
// Contents: MODE_* 2-bit constants used by every mode decode.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_SHIFT_R = 2'b01;
  localparam logic [1:0] MODE_SHIFT_L = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// Purpose : one WIDTH-bit stage of the universal shift register.
//           4:1 mux (hold / right neighbour / left neighbour / parallel load)
//           feeding a DFF with synchronous active-low clear.
// Ports   : clk, reset_n   clock and synchronous active-low clear
//           en             clock enable, 0 freezes the stage
//           mode           operation select (shift_pkg MODE_*)
//           i_shr          data taken on SHIFT_R (lower-index neighbour or sin_r)
//           i_shl          data taken on SHIFT_L (higher-index neighbour or sin_l)
//           i_load         data taken on LOAD
//           o_q            registered stage value
module shift_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] i_shr,
  input  logic [WIDTH-1:0] i_shl,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_q
);
  import shift_pkg::*;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;

  always_comb begin
    w_d = r_q;
    case (mode)
      MODE_HOLD:    w_d = r_q;
      MODE_SHIFT_R: w_d = i_shr;
      MODE_SHIFT_L: w_d = i_shl;
      MODE_LOAD:    w_d = i_load;
      default:      w_d = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Purpose : parametrised universal shift register, DEPTH stages of WIDTH bits.
//           Hold, shift-right, shift-left and parallel load; a frame counter
//           pulses frame_done when a full word has been shifted in or out.
// Ports   : clk, reset_n   clock and synchronous active-low reset
//           en             clock enable, 0 freezes all state
//           mode           00 HOLD, 01 SHIFT_R, 10 SHIFT_L, 11 LOAD
//           sin_r / sin_l  serial inputs entering stage 0 / stage DEPTH-1
//           pin            parallel load word, slice i -> stage i
//           sout_r/sout_l  stage DEPTH-1 / stage 0
//           pout           all stages, slice i = stage i
//           shift_cnt      shifts since last LOAD or frame wrap
//           frame_done     registered one-cycle pulse on the frame's last shift
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [CNT_W-1:0]       shift_cnt,
  output logic                   frame_done
);
  import shift_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] w_stage [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_shift;

  // End stages take the serial inputs; inner stages chain to their neighbours.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    if (g == 0) begin : g_first
      assign w_shr = sin_r;
    end else begin : g_inner_r
      assign w_shr = w_stage[g-1];
    end

    if (g == DEPTH - 1) begin : g_last
      assign w_shl = sin_l;
    end else begin : g_inner_l
      assign w_shl = w_stage[g+1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .mode    (mode),
      .i_shr   (w_shr),
      .i_shl   (w_shl),
      .i_load  (pin[g*WIDTH +: WIDTH]),
      .o_q     (w_stage[g])
    );

    assign pout[g*WIDTH +: WIDTH] = w_stage[g];
  end

  assign w_shift = (mode == MODE_SHIFT_R) || (mode == MODE_SHIFT_L);

  // Both directions advance the same frame; only LOAD or reset restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        if (mode == MODE_LOAD) begin
          r_cnt <= '0;
        end else if (w_shift) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign sout_r     = w_stage[DEPTH-1];
  assign sout_l     = w_stage[0];
  assign shift_cnt  = r_cnt;
  assign frame_done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;

  logic       a_sin_r, a_sin_l;
  logic [2:0] a_pin, a_pout;
  logic       a_sout_r, a_sout_l;
  logic [1:0] a_cnt;
  logic       a_done;

  logic [3:0]  b_sin_r, b_sin_l;
  logic [31:0] b_pin, b_pout;
  logic [3:0]  b_sout_r, b_sout_l;
  logic [3:0]  b_cnt;
  logic        b_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wa, wb;
  int          na, nb;
  logic        da, db;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(1), .DEPTH(3)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .en(en), .mode(mode),
    .sin_r(a_sin_r), .sin_l(a_sin_l), .pin(a_pin),
    .sout_r(a_sout_r), .sout_l(a_sout_l), .pout(a_pout),
    .shift_cnt(a_cnt), .frame_done(a_done)
  );

  univ_shift_reg #(.WIDTH(4), .DEPTH(8)) u_dut_b (
    .clk(clk), .reset_n(rst_n), .en(en), .mode(mode),
    .sin_r(b_sin_r), .sin_l(b_sin_l), .pin(b_pin),
    .sout_r(b_sout_r), .sout_l(b_sout_l), .pout(b_pout),
    .shift_cnt(b_cnt), .frame_done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word model: stage i is lane i of an integer; shifting right moves data
  // toward higher lanes. n counts shifts in the current frame.
  task automatic mdl(input int d, input int w, input logic r, input logic e,
                     input logic [1:0] m, input logic [63:0] sr, input logic [63:0] sl,
                     input logic [63:0] pn, inout logic [63:0] word, inout int n,
                     output logic done);
    logic [63:0] msk;
    msk  = (64'd1 << (d * w)) - 64'd1;
    done = 1'b0;
    if (!r) begin
      word = '0;
      n    = 0;
    end else if (e) begin
      case (m)
        2'b11: begin word = pn & msk; n = 0; end
        2'b01: begin
          word = ((word << w) | sr) & msk;
          n++;
          done = (n % d == 0);
        end
        2'b10: begin
          word = (word >> w) | (sl << ((d - 1) * w));
          n++;
          done = (n % d == 0);
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl(3, 1, rst_n, en, mode, 64'(a_sin_r), 64'(a_sin_l), 64'(a_pin), wa, na, da);
    mdl(8, 4, rst_n, en, mode, 64'(b_sin_r), 64'(b_sin_l), 64'(b_pin), wb, nb, db);
    #1;
    chk("a_pout",   64'(a_pout),   wa);
    chk("a_sout_r", 64'(a_sout_r), (wa >> 2) & 64'h1);
    chk("a_sout_l", 64'(a_sout_l), wa & 64'h1);
    chk("a_cnt",    64'(a_cnt),    64'(na % 3));
    chk("a_done",   64'(a_done),   64'(da));
    chk("b_pout",   64'(b_pout),   wb);
    chk("b_sout_r", 64'(b_sout_r), (wb >> 28) & 64'hF);
    chk("b_sout_l", 64'(b_sout_l), wb & 64'hF);
    chk("b_cnt",    64'(b_cnt),    64'(nb % 8));
    chk("b_done",   64'(b_done),   64'(db));
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m);
    rst_n = r;
    en    = e;
    mode  = m;
  endtask

  initial begin
    int pulses;
    wa = '0; wb = '0; na = 0; nb = 0; da = 1'b0; db = 1'b0;
    a_sin_r = 0; a_sin_l = 0; a_pin = 3'b111;
    b_sin_r = 0; b_sin_l = 0; b_pin = 32'hFFFF_FFFF;

    // Reset wins over en and LOAD
    drive(1'b0, 1'b1, 2'b11);
    step(); step();
    chk("rst_pout", 64'(a_pout), 64'h0);
    chk("rst_cnt",  64'(a_cnt),  64'h0);
    chk("rst_done", 64'(a_done), 64'h0);

    // SIPO: 1,0,1
    drive(1'b1, 1'b1, 2'b01);
    a_sin_r = 1; step(); chk("sipo_cnt1", 64'(a_cnt), 64'd1); chk("sipo_done1", 64'(a_done), 64'd0);
    a_sin_r = 0; step(); chk("sipo_cnt2", 64'(a_cnt), 64'd2); chk("sipo_done2", 64'(a_done), 64'd0);
    a_sin_r = 1; step(); chk("sipo_cnt3", 64'(a_cnt), 64'd0); chk("sipo_done3", 64'(a_done), 64'd1);
    chk("sipo_pout", 64'(a_pout), 64'b101);
    chk("sipo_sout_r", 64'(a_sout_r), 64'd1);

    // PISO: load 110, drain right
    drive(1'b1, 1'b1, 2'b11); a_pin = 3'b110; step();
    chk("piso_load", 64'(a_sout_r), 64'd1);
    drive(1'b1, 1'b1, 2'b01); a_sin_r = 0;
    step(); chk("piso_s1", 64'(a_sout_r), 64'd1);
    step(); chk("piso_s2", 64'(a_sout_r), 64'd0);
    step(); chk("piso_s3", 64'(a_sout_r), 64'd0); chk("piso_done", 64'(a_done), 64'd1);
    chk("piso_pout", 64'(a_pout), 64'd0);

    // Left path: load 001, shift in ones
    drive(1'b1, 1'b1, 2'b11); a_pin = 3'b001; step();
    chk("left_load", 64'(a_sout_l), 64'd1);
    drive(1'b1, 1'b1, 2'b10); a_sin_l = 1;
    step(); chk("left_s1", 64'(a_sout_l), 64'd0);
    step(); chk("left_s2", 64'(a_sout_l), 64'd0);
    step(); chk("left_s3", 64'(a_sout_l), 64'd1);
    chk("left_pout", 64'(a_pout), 64'b111);

    // en gap mid-frame
    drive(1'b1, 1'b1, 2'b01); a_sin_r = 1; step(); step();
    drive(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gap_cnt", 64'(a_cnt), 64'd2);
      chk("gap_done", 64'(a_done), 64'd0);
    end
    drive(1'b1, 1'b1, 2'b01); step();
    chk("gap_resume_done", 64'(a_done), 64'd1);

    // Reset mid-frame discards progress
    step(); step();
    drive(1'b0, 1'b1, 2'b01); step();
    chk("midrst_cnt", 64'(a_cnt), 64'd0);
    chk("midrst_pout", 64'(a_pout), 64'd0);
    drive(1'b1, 1'b1, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("midrst_frame", 64'(a_done), 64'(i == 3));
    end

    // Wide instance: nibbles 1..8 shifted right
    drive(1'b0, 1'b1, 2'b00); step();
    drive(1'b1, 1'b1, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      b_sin_r = 4'(k);
      step();
      chk("wide_done", 64'(b_done), 64'(k == 8));
    end
    chk("wide_pout", 64'(b_pout), 64'h1234_5678);
    chk("wide_sout_r", 64'(b_sout_r), 64'h1);

    // Mixed directions still pulse every 8 shifts
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
      b_sin_r = 4'($urandom); b_sin_l = 4'($urandom);
      step();
      if (b_done) pulses++;
    end
    chk("mixed_pulses", 64'(pulses), 64'd2);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));
      a_sin_r = 1'($urandom); a_sin_l = 1'($urandom); a_pin = 3'($urandom);
      b_sin_r = 4'($urandom); b_sin_l = 4'($urandom); b_pin = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
